// File: rtl/snn_pkg.sv
// snn_pkg: shared widths, arbiter state encoding and event source encoding
package snn_pkg;
  localparam int NEURON_WIDTH = 11;
  localparam int BT_WIDTH     = 36;
  localparam int COUNT_WIDTH  = 16;
  typedef enum logic [2:0] {IDLE, SELECT, FETCH, PRESENT, DONE} state_t;
  typedef enum logic {SRC_INPUT = 1'b0, SRC_AUX = 1'b1} src_t;
endpackage

// File: rtl/spike_head_select.sv
// spike_head_select: picks the eligible FIFO head with the earliest BT, Input wins ties
module spike_head_select
  import snn_pkg::*;
#(
  parameter int W = snn_pkg::BT_WIDTH
) (
  input  logic [W-1:0] i_in_head,
  input  logic         i_in_empty,
  input  logic [W-1:0] i_aux_head,
  input  logic         i_aux_empty,
  input  logic [W-1:0] i_cur_bt,
  output logic         o_any_eligible,
  output src_t         o_winner
);
  logic w_in_ok, w_aux_ok;
  // a head is eligible when present and not in the future; Aux only wins on a strictly earlier BT
  always_comb begin
    w_in_ok        = !i_in_empty && (i_in_head <= i_cur_bt);
    w_aux_ok       = !i_aux_empty && (i_aux_head <= i_cur_bt);
    o_any_eligible = w_in_ok || w_aux_ok;
    o_winner       = (w_aux_ok && (!w_in_ok || i_aux_head < i_in_head)) ? SRC_AUX : SRC_INPUT;
  end
endmodule

// File: rtl/spike_event_arbiter.sv
// spike_event_arbiter: drains Input/Aux spike FIFOs in BT order onto a valid/ready event port
module spike_event_arbiter #(
  parameter int NEURON_WIDTH = snn_pkg::NEURON_WIDTH,
  parameter int BT_WIDTH     = snn_pkg::BT_WIDTH,
  parameter int COUNT_WIDTH  = snn_pkg::COUNT_WIDTH
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic [BT_WIDTH-1:0]     Current_BT,
  input  logic [BT_WIDTH-1:0]     InBT_Head,
  input  logic                    InIsQueueEmpty,
  input  logic [BT_WIDTH-1:0]     InBTOut,
  input  logic [NEURON_WIDTH-1:0] InNIDOut,
  output logic                    InDequeue,
  input  logic [BT_WIDTH-1:0]     AuxBT_Head,
  input  logic                    AuxIsQueueEmpty,
  input  logic [BT_WIDTH-1:0]     AuxBTOut,
  input  logic [NEURON_WIDTH-1:0] AuxNIDOut,
  output logic                    AuxDequeue,
  output logic                    EventValid,
  input  logic                    EventReady,
  output logic [BT_WIDTH-1:0]     EventBT,
  output logic [NEURON_WIDTH-1:0] EventNID,
  output logic                    EventSource,
  output logic [COUNT_WIDTH-1:0]  EventCount,
  output logic                    DrainComplete
);
  import snn_pkg::*;
  state_t                  r_state, w_next;
  src_t                    r_src, w_winner;
  logic                    w_any, w_take;
  logic                    r_valid, r_done;
  logic [BT_WIDTH-1:0]     r_bt;
  logic [NEURON_WIDTH-1:0] r_nid;
  logic [COUNT_WIDTH-1:0]  r_count;
  spike_head_select #(.W(BT_WIDTH)) u_sel (
    .i_in_head     (InBT_Head),
    .i_in_empty    (InIsQueueEmpty),
    .i_aux_head    (AuxBT_Head),
    .i_aux_empty   (AuxIsQueueEmpty),
    .i_cur_bt      (Current_BT),
    .o_any_eligible(w_any),
    .o_winner      (w_winner)
  );
  // state register
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) r_state <= IDLE;
    else        r_state <= w_next;
  // next state: an in-flight event always completes before Enable low returns to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = Enable ? SELECT : IDLE;
      SELECT:  w_next = !Enable ? IDLE : (w_any ? FETCH : DONE);
      FETCH:   w_next = PRESENT;
      PRESENT: w_next = !EventReady ? PRESENT : (Enable ? SELECT : IDLE);
      DONE:    w_next = Enable ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  // dequeue pulses: only the winner, only during SELECT, only with something eligible
  always_comb begin
    w_take     = (r_state == SELECT) && Enable && w_any;
    InDequeue  = w_take && (w_winner == SRC_INPUT);
    AuxDequeue = w_take && (w_winner == SRC_AUX);
  end
  // event register, drain counter and completion pulse
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      r_src   <= SRC_INPUT;
      r_bt    <= '0;
      r_nid   <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == SELECT) && (w_next == DONE);
      if (r_state == IDLE && Enable) r_count <= '0;
      if (w_take) r_src <= w_winner;
      if (r_state == FETCH) begin
        r_bt    <= (r_src == SRC_AUX) ? AuxBTOut : InBTOut;
        r_nid   <= (r_src == SRC_AUX) ? AuxNIDOut : InNIDOut;
        r_valid <= 1'b1;
      end
      if (r_state == PRESENT && r_valid && EventReady) begin
        r_valid <= 1'b0;
        r_count <= (r_count == '1) ? r_count : r_count + 1'b1;
      end
    end
  assign EventValid    = r_valid;
  assign EventBT       = r_bt;
  assign EventNID      = r_nid;
  assign EventSource   = r_src;
  assign EventCount    = r_count;
  assign DrainComplete = r_done;
endmodule

// File: doc/spike_event_arbiter.md
Name: spike_event_arbiter

Overview:
- Downstream consumer of the Input and Aux spike FIFOs that the internal router fills with {BT, NID} events.
- Each timestep it drains, in binary-time order, every queued event whose BT ≤ Current_BT from both FIFOs.
- Drained events are presented one at a time over a valid/ready handshake to the synaptic-processing stage.
- Future events (BT > Current_BT) stay queued.

Parameters:
- NEURON_WIDTH, 11, neuron-ID width.
- BT_WIDTH, 36, binary-time width (32 integer + 4 fraction bits).
- COUNT_WIDTH, 16, width of the per-drain event counter.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Enable  in  1  level; high requests a drain for Current_BT.
- Current_BT  in  BT_WIDTH  current timestep BT.
- InBT_Head  in  BT_WIDTH  Input FIFO head BT (combinational).
- InIsQueueEmpty  in  1  Input FIFO empty.
- InBTOut  in  BT_WIDTH  Input FIFO dequeued BT (valid cycle after Dequeue).
- InNIDOut  in  NEURON_WIDTH  Input FIFO dequeued NID.
- InDequeue  out  1  Input FIFO dequeue pulse.
- AuxBT_Head, AuxIsQueueEmpty, AuxBTOut, AuxNIDOut, AuxDequeue  same as Input equivalents, for the Aux FIFO.
- EventValid  out  1  event available.
- EventReady  in  1  consumer accepts.
- EventBT  out  BT_WIDTH  event BT.
- EventNID  out  NEURON_WIDTH  event NID.
- EventSource  out  1  0 = Input, 1 = Aux.
- EventCount  out  COUNT_WIDTH  events delivered in current/last drain.
- DrainComplete  out  1  one-cycle pulse at drain end.

Behaviour:
- Reset (Reset = 0, async): state IDLE; all outputs 0, including EventCount, both Dequeues, EventValid and DrainComplete.
- Eligibility:
  - A queue is eligible when !IsQueueEmpty and Head ≤ Current_BT, using a full-width unsigned compare.
  - If both are eligible, the smaller Head wins. On a tie, Input wins.
- States and transitions:
  - IDLE: on Enable = 1, clear EventCount and go to SELECT.
  - SELECT:
    - Enable = 0 → IDLE, with no DrainComplete.
    - No eligible queue → DONE.
    - Otherwise assert the winner's Dequeue for exactly this cycle, latch the source, and go to FETCH.
  - FETCH: FIFO data is valid this cycle. Register BTOut/NIDOut into EventBT/EventNID, set EventValid = 1, go to PRESENT.
  - PRESENT:
    - Hold EventBT, EventNID and EventSource stable while EventValid && !EventReady.
    - On EventValid && EventReady: clear EventValid, increment EventCount (saturating at all-ones), then go to SELECT if Enable = 1, else IDLE.
  - DONE: assert DrainComplete for one cycle on entry. Remain in DONE while Enable = 1; go to IDLE when Enable = 0.
- Latency and throughput:
  - First EventValid appears 2 cycles after Enable is sampled high.
  - Minimum 3 cycles per event when EventReady is tied high.
- Dequeue discipline:
  - InDequeue and AuxDequeue are never high together.
  - They are never asserted outside SELECT and never asserted on an empty queue.
- Dropping Enable mid-event (FETCH/PRESENT): the in-flight event is still delivered, then the block goes to IDLE. No event is lost.
- Mid-drain refills: FIFO heads are re-evaluated on every SELECT entry. Events enqueued during the drain with BT ≤ Current_BT are drained in the same pass.
- Current_BT must be stable while Enable = 1. It is sampled only in SELECT.
- Reset asserted mid-drain: immediate return to IDLE, outputs cleared. The partially presented event is discarded.

Decomposition:
- Shared package (snn_pkg):
  - NEURON_WIDTH and BT_WIDTH defaults.
  - State encoding: IDLE, SELECT, FETCH, PRESENT, DONE.
  - Source encoding: SRC_INPUT = 0, SRC_AUX = 1.
- One natural sub-module: spike_head_select, combinational. It takes both heads, both empty flags and Current_BT, and produces any_eligible and winner.

Test Plan:
- Current_BT = 0x50. Input head 0x48 NID 3; Aux head 0x40 NID 410. EventReady = 1 → events (0x40, 410, Aux) then (0x48, 3, Input); EventCount = 2; one DrainComplete pulse.
- Both heads 0x50 (NID 7 Input, NID 420 Aux) → Input event delivered first, then Aux.
- Only Input head 0x58 > 0x50, Aux empty → no Dequeue; DrainComplete 1 cycle after SELECT; EventCount = 0; queue untouched.
- EventReady held low for 5 cycles with event (0x40, 410) pending → EventValid high and data stable all 5 cycles; no further Dequeue until accept.
- Enable dropped during PRESENT → current event completes on Ready; next state IDLE; no DrainComplete; remaining eligible events still queued.
- Reset pulled low during FETCH → same cycle EventValid = 0, both Dequeues = 0, EventCount = 0; after release, Enable restarts a clean drain.
